// File: rtl/mux_serializer_pkg.sv
// Shared types for the 64-bit mux serializer: word/index typedefs, FSM states and
// the counter-to-select bit-order mapping.
package mux_serializer_pkg;

    localparam int SEL_W = 6;
    localparam int WIDTH = 2 ** SEL_W;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEL_W-1:0] idx_t;

    // PARITY is only reachable when SERIALIZER_PARITY_EN is defined
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } ser_state_t;

    function automatic idx_t sel_map(input idx_t idx, input bit msb_first);
        return msb_first ? ~idx : idx;
    endfunction

endpackage

// File: rtl/multiplexor6.sv
// 64:1 bit selector: out is in[sel].
module multiplexor6 (
    input  logic [63:0] in,
    input  logic [5:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage feeding multiplexor6 from a shadow word and a bit counter.
// Define SERIALIZER_PARITY_EN to append an even-parity beat after each word.
module mux_serializer #(
    parameter int SEL_W     = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**SEL_W-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_last,
    output logic [SEL_W-1:0]      bit_idx,
    output logic                  busy
);

    import mux_serializer_pkg::*;

    localparam logic [SEL_W-1:0] idx_last = '1;

    ser_state_t             state;
    logic [2**SEL_W-1:0]    shadow;
    logic [SEL_W-1:0]       idx;
    logic [SEL_W-1:0]       sel;
    logic                   mux_out;
    logic                   at_end;
    logic                   in_beat;
    logic                   out_beat;

    assign sel       = sel_map(idx, MSB_FIRST);
    assign at_end    = (idx == idx_last);
    assign ser_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign bit_idx   = idx;
    assign in_beat   = din_valid && din_ready;
    assign out_beat  = ser_valid && ser_ready;

    multiplexor6 u_sel (
        .in  (shadow),
        .sel (sel),
        .out (mux_out)
    );

`ifdef SERIALIZER_PARITY_EN
    assign din_ready = (state == IDLE) || ((state == PARITY) && ser_ready);
    assign ser_last  = (state == PARITY);
    assign ser_out   = (state == PARITY) ? ^shadow : mux_out;
`else
    // Only combinational path from ser_ready: lets the next word land on the last beat
    assign din_ready = (state == IDLE) || ((state == SHIFT) && at_end && ser_ready);
    assign ser_last  = (state == SHIFT) && at_end;
    assign ser_out   = mux_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_beat) begin
                        shadow <= din;
                        idx    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_beat) begin
                        if (!at_end) begin
                            idx <= idx + 1'b1;
                        end else begin
`ifdef SERIALIZER_PARITY_EN
                            // idx holds at the last position through the parity beat
                            state <= PARITY;
`else
                            idx <= '0;
                            if (in_beat) begin
                                shadow <= din;
                            end else begin
                                state <= IDLE;
                            end
`endif
                        end
                    end
                end
                PARITY: begin
`ifdef SERIALIZER_PARITY_EN
                    if (out_beat) begin
                        idx <= '0;
                        if (in_beat) begin
                            shadow <= din;
                            state  <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer: LSB-first and MSB-first instances share stimulus;
// a negedge monitor pops expected beats whenever a beat is presented and consumed.
module tb_mux_serializer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [63:0] din       = '0;
    logic        din_valid = 1'b0;
    logic        ser_ready = 1'b0;

    logic       din_ready0, ser_out0, ser_valid0, ser_last0, busy0;
    logic [5:0] bit_idx0;
    logic       din_ready1, ser_out1, ser_valid1, ser_last1, busy1;
    logic [5:0] bit_idx1;

    typedef struct packed {
        logic       b0;
        logic       b1;
        logic       last;
        logic [5:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef SERIALIZER_PARITY_EN
    localparam int BEATS = 65;
`else
    localparam int BEATS = 64;
`endif

    mux_serializer #(.SEL_W(6), .MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready0),
        .ser_out   (ser_out0),
        .ser_valid (ser_valid0),
        .ser_ready (ser_ready),
        .ser_last  (ser_last0),
        .bit_idx   (bit_idx0),
        .busy      (busy0)
    );

    mux_serializer #(.SEL_W(6), .MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready1),
        .ser_out   (ser_out1),
        .ser_valid (ser_valid1),
        .ser_ready (ser_ready),
        .ser_last  (ser_last1),
        .bit_idx   (bit_idx1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push_word(input logic [63:0] w);
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.b0   = w[k];
            e.b1   = w[63-k];
            e.idx  = 6'(k);
`ifdef SERIALIZER_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (k == 63);
`endif
            sb.push_back(e);
        end
`ifdef SERIALIZER_PARITY_EN
        e.b0   = ^w;
        e.b1   = ^w;
        e.last = 1'b1;
        e.idx  = 6'd63;
        sb.push_back(e);
`endif
    endtask

    // Leaves din_valid high on return; caller drops it when the stream ends.
    task automatic send(input logic [63:0] w);
        din       = w;
        din_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (din_ready0) begin
                push_word(w);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept timeout din_ready", din_ready0, 1'b1);
    endtask

    task automatic wait_idx(input logic [5:0] v);
        for (int c = 0; c < 300; c++) begin
            if (bit_idx0 == v) return;
            @(posedge clk);
            #1;
        end
        check("bit_idx wait timeout", bit_idx0, v);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!ser_valid0) return;
        end
        check("idle wait timeout ser_valid", ser_valid0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ser_valid"}, ser_valid0, 1'b0);
        check({tag, " busy"}, busy0, 1'b0);
        check({tag, " din_ready"}, din_ready0, 1'b1);
        check({tag, " bit_idx"}, bit_idx0, 6'd0);
        check({tag, " ser_last"}, ser_last0, 1'b0);
        check({tag, " ser_out"}, ser_out0, 1'b0);
        check({tag, " msb dut outputs"}, {ser_valid1, busy1, din_ready1, bit_idx1, ser_last1,
                                          ser_out1}, 11'b00100000000);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_ready;
        if (rst_n) begin
            if (!ser_valid0) begin
                check("idle din_ready", din_ready0, 1'b1);
            end else if (sb.size() == 0) begin
                check("unexpected ser_valid", ser_valid0, 1'b0);
            end else begin
                e         = sb[0];
                exp_ready = ser_ready && e.last;
                check("ser_out", ser_out0, e.b0);
                check("ser_last", ser_last0, e.last);
                check("bit_idx", bit_idx0, e.idx);
                check("din_ready", din_ready0, exp_ready);
                check("busy", busy0, 1'b1);
                check("msb dut beat", {ser_out1, ser_last1, bit_idx1, din_ready1, busy1,
                                       ser_valid1}, {e.b1, e.last, e.idx, exp_ready, 2'b11});
                if (ser_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin : main
        int gaps;

        // Async reset mid-cycle, checked before any clock edge
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, LSB first, no backpressure
        ser_ready = 1'b1;
        send(64'h0000_0000_0000_0001);
        din_valid = 1'b0;
        @(negedge clk);
        check("first beat latency ser_valid", ser_valid0, 1'b1);
        check("first beat bit_idx", bit_idx0, 6'd0);
        for (int c = 0; c < 100; c++) begin
            if (ser_valid0 && ser_last0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("after last ser_valid", ser_valid0, 1'b0);
        check("after last busy", busy0, 1'b0);

        // Backpressure held at idx 10
        @(posedge clk);
        #1;
        send(64'hFFFF_FFFF_FFFF_FFFE);
        din_valid = 1'b0;
        wait_idx(6'd10);
        ser_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall bit_idx", bit_idx0, 6'd10);
            check("stall ser_out", ser_out0, 1'b1);
            check("stall ser_valid", ser_valid0, 1'b1);
        end
        @(posedge clk);
        #1;
        ser_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resume bit_idx", bit_idx0, 6'd11);
        wait_idle();

        // Back-to-back words with no bubble
        @(posedge clk);
        #1;
        fork
            begin
                send(64'hA5A5_A5A5_A5A5_A5A5);
                send(64'h0000_0000_0000_0001);
                din_valid = 1'b0;
            end
        join_none
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ser_valid0) break;
        end
        gaps = 0;
        for (int i = 1; i < 2 * BEATS; i++) begin
            @(negedge clk);
            if (!ser_valid0) gaps++;
        end
        check("back-to-back gaps", gaps, 0);
        @(negedge clk);
        check("back-to-back end ser_valid", ser_valid0, 1'b0);

        // Reset mid-word aborts; MSB-first word afterwards
        @(posedge clk);
        #1;
        send(64'h0123_4567_89AB_CDEF);
        din_valid = 1'b0;
        wait_idx(6'd30);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid-word reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'h8000_0000_0000_0000);
        din_valid = 1'b0;
        @(negedge clk);
        check("msb-first beat0 ser_out", ser_out1, 1'b1);
        check("lsb-first beat0 ser_out", ser_out0, 1'b0);
        wait_idle();

`ifdef SERIALIZER_PARITY_EN
        @(posedge clk);
        #1;
        send(64'h0000_0000_0000_0007);
        din_valid = 1'b0;
        wait_idle();
`endif

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
